lsu_mem_arbiter: RTL

//  Shares one data-memory port among NUM_REQ per-thread LSU requesters of a core.

---
 rtl/lsu_mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ LSU requesters.
// One transaction in flight; the requester's ready is held until it drops valid.
module lsu_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           lsu_read_valid_flat,
    input  logic [NUM_REQ-1:0]           lsu_write_valid_flat,
    input  logic [NUM_REQ*ADDR_BITS-1:0] lsu_read_addr_flat,
    input  logic [NUM_REQ*ADDR_BITS-1:0] lsu_write_addr_flat,
    input  logic [NUM_REQ*DATA_BITS-1:0] lsu_write_data_flat,
    output logic [NUM_REQ-1:0]           lsu_ready_flat,
    output logic [NUM_REQ*DATA_BITS-1:0] lsu_read_data_flat,
    output logic                         mem_read_valid,
    output logic [ADDR_BITS-1:0]         mem_read_addr,
    input  logic                         mem_read_ready,
    input  logic [DATA_BITS-1:0]         mem_read_data,
    output logic                         mem_write_valid,
    output logic [ADDR_BITS-1:0]         mem_write_addr,
    output logic [DATA_BITS-1:0]         mem_write_data,
    input  logic                         mem_write_ready,
    output logic                         busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t                            state;
    logic [IDX_W-1:0]                  last, sel, pick;
    logic                              found;
    logic [NUM_REQ-1:0]                req_any;
    logic [NUM_REQ-1:0][ADDR_BITS-1:0] rd_addr, wr_addr;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] wr_data, rd_data_q;

    assign rd_addr            = lsu_read_addr_flat;
    assign wr_addr            = lsu_write_addr_flat;
    assign wr_data            = lsu_write_data_flat;
    assign req_any            = lsu_read_valid_flat | lsu_write_valid_flat;
    assign lsu_read_data_flat = rd_data_q;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_any[(int'(last) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            last            <= IDX_W'(NUM_REQ - 1);
            sel             <= '0;
            mem_read_valid  <= 1'b0;
            mem_read_addr   <= '0;
            mem_write_valid <= 1'b0;
            mem_write_addr  <= '0;
            mem_write_data  <= '0;
            lsu_ready_flat  <= '0;
            rd_data_q       <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sel  <= pick;
                        last <= pick;
                        busy <= 1'b1;
                        // A requester with both valids is served as a read first.
                        if (lsu_read_valid_flat[pick]) begin
                            mem_read_valid <= 1'b1;
                            mem_read_addr  <= rd_addr[pick];
                            state          <= READ_WAIT;
                        end else begin
                            mem_write_valid <= 1'b1;
                            mem_write_addr  <= wr_addr[pick];
                            mem_write_data  <= wr_data[pick];
                            state           <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        mem_read_valid      <= 1'b0;
                        rd_data_q[sel]      <= mem_read_data;
                        lsu_ready_flat[sel] <= 1'b1;
                        state               <= RELAY;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        mem_write_valid     <= 1'b0;
                        lsu_ready_flat[sel] <= 1'b1;
                        state               <= RELAY;
                    end
                end
                RELAY: begin
                    if (!lsu_read_valid_flat[sel] && !lsu_write_valid_flat[sel]) begin
                        lsu_ready_flat <= '0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
